// File: rtl/fpu_op_scheduler.sv
// rtl/fpu_op_scheduler.sv - two-requester round-robin scheduler for one shared registered FP datapath
// Optional divide-by-zero trap (signed infinity, rsp_err, dz_sticky) enabled by FPU_SCHED_DZ_TRAP_EN.
module fpu_op_scheduler #(
    parameter int LAT = 1,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         dp_en,
    output logic [1:0]   dp_op,
    output logic [W-1:0] dp_a,
    output logic [W-1:0] dp_b,
    input  logic [W-1:0] dp_result,
    input  logic         dp_zero_div,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_result,
`ifdef FPU_SCHED_DZ_TRAP_EN
    output logic         dz_sticky,
`endif
    output logic         rsp_err
);

    localparam int           CW     = 4;
    localparam logic [1:0]   OP_DIV = 2'b10;
    localparam logic [1:0]   OP_ILL = 2'b11;
    localparam logic [W-1:0] QNAN   = W'(32'h7FC0_0000);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic           last_grant;
    logic           grant;
    logic           accept;
    logic [CW-1:0]  cnt;
    logic [1:0]     sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   cap_result;
    logic           cap_err;

    // A lone requester always wins; on a tie the one not served last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req1_valid;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign sel_op     = grant ? req1_op : req0_op;
    assign sel_a      = grant ? req1_a  : req0_a;
    assign sel_b      = grant ? req1_b  : req0_b;

    assign dp_en     = (state == ISSUE) || (state == WAIT);
    assign rsp_valid = (state == RESP);

`ifdef FPU_SCHED_DZ_TRAP_EN
    logic cap_dz;
    assign cap_dz = (dp_op == OP_DIV) && dp_zero_div;

    always_comb begin
        cap_result = dp_result;
        cap_err    = 1'b0;
        if (cap_dz) begin
            cap_result = {dp_a[W-1] ^ dp_b[W-1], 8'hFF, {(W-9){1'b0}}};
            cap_err    = 1'b1;
        end
    end
`else
    logic unused_dz;
    assign unused_dz  = dp_zero_div;
    assign cap_result = dp_result;
    assign cap_err    = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (sel_op == OP_ILL) ? RESP : ISSUE;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (cnt == '0) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand/op registers double as the datapath drive and stay put until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cnt        <= '0;
            dp_op      <= '0;
            dp_a       <= '0;
            dp_b       <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
`ifdef FPU_SCHED_DZ_TRAP_EN
            dz_sticky  <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_grant <= grant;
                        rsp_id     <= grant;
                        dp_op      <= sel_op;
                        dp_a       <= sel_a;
                        dp_b       <= sel_b;
                        if (sel_op == OP_ILL) begin
                            rsp_result <= QNAN;
                            rsp_err    <= 1'b1;
                        end
                    end
                end
                ISSUE: cnt <= CW'(LAT - 1);
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_result <= cap_result;
                        rsp_err    <= cap_err;
`ifdef FPU_SCHED_DZ_TRAP_EN
                        if (cap_dz) begin
                            dz_sticky <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// tb/tb_fpu_op_scheduler.sv - directed vector bench for fpu_op_scheduler (LAT=1 main instance, LAT=3 second instance)
module tb_fpu_op_scheduler;
    localparam int W   = 32;
    localparam int LAT = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         dp_en;
    logic [1:0]   dp_op;
    logic [W-1:0] dp_a, dp_b;
    logic [W-1:0] dp_result = '0;
    logic         dp_zero_div = 1'b0;
    logic         rsp_valid, rsp_id, rsp_err;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
`ifdef FPU_SCHED_DZ_TRAP_EN
    logic         dz_sticky;
    logic         d3_dz_sticky;
`endif

    logic         r3_valid = 1'b0, r3_ready, r3_rsp_ready = 1'b0;
    logic [1:0]   r3_op = '0;
    logic [W-1:0] r3_a = '0, r3_b = '0;
    logic         q3_valid = 1'b0, q3_ready;
    logic [1:0]   q3_op = '0;
    logic [W-1:0] q3_a = '0, q3_b = '0;
    logic         d3_en;
    logic [1:0]   d3_op;
    logic [W-1:0] d3_a, d3_b, d3_result;
    logic         d3_zero_div;
    logic         r3_rsp_valid, r3_rsp_id, r3_rsp_err;
    logic [W-1:0] r3_rsp_result;

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;
    int en3_cycles = 0;

    fpu_op_scheduler #(.LAT(LAT), .W(W)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .dp_en(dp_en), .dp_op(dp_op), .dp_a(dp_a), .dp_b(dp_b),
        .dp_result(dp_result), .dp_zero_div(dp_zero_div),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
`ifdef FPU_SCHED_DZ_TRAP_EN
        .dz_sticky(dz_sticky),
`endif
        .rsp_err(rsp_err)
    );

    fpu_op_scheduler #(.LAT(3), .W(W)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(r3_valid), .req0_ready(r3_ready), .req0_op(r3_op), .req0_a(r3_a), .req0_b(r3_b),
        .req1_valid(q3_valid), .req1_ready(q3_ready), .req1_op(q3_op), .req1_a(q3_a), .req1_b(q3_b),
        .dp_en(d3_en), .dp_op(d3_op), .dp_a(d3_a), .dp_b(d3_b),
        .dp_result(d3_result), .dp_zero_div(d3_zero_div),
        .rsp_valid(r3_rsp_valid), .rsp_ready(r3_rsp_ready), .rsp_id(r3_rsp_id), .rsp_result(r3_rsp_result),
`ifdef FPU_SCHED_DZ_TRAP_EN
        .dz_sticky(d3_dz_sticky),
`endif
        .rsp_err(r3_rsp_err)
    );

    // Hand-computed IEEE754 single results for the operand pairs used below.
    function automatic logic [W-1:0] fp_ref(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case ({op, a, b})
            {2'd0, 32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {2'd0, 32'h3F800000, 32'h40000000}: return 32'h40400000;
            {2'd1, 32'h40000000, 32'h40400000}: return 32'h40C00000;
            {2'd2, 32'h40400000, 32'h40000000}: return 32'h3FC00000;
            {2'd2, 32'hC0800000, 32'h40000000}: return 32'hC0000000;
            {2'd2, 32'h40800000, 32'h40000000}: return 32'h40000000;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        dp_result   <= dp_en ? fp_ref(dp_op, dp_a, dp_b) : '0;
        dp_zero_div <= dp_en && (dp_op == 2'd2) && (dp_b == '0);
        if (dp_en) en_cycles <= en_cycles + 1;
    end

    logic [2:0][W-1:0] p3 = '0;
    logic [2:0]        z3 = '0;
    always @(posedge clk) begin
        p3[0] <= d3_en ? fp_ref(d3_op, d3_a, d3_b) : '0;
        p3[1] <= d3_en ? p3[0] : '0;
        p3[2] <= d3_en ? p3[1] : '0;
        z3[0] <= d3_en && (d3_op == 2'd2) && (d3_b == '0);
        z3[1] <= d3_en && z3[0];
        z3[2] <= d3_en && z3[1];
        if (d3_en) en3_cycles <= en3_cycles + 1;
    end
    assign d3_result   = p3[2];
    assign d3_zero_div = z3[2];

`ifdef FPU_SCHED_DZ_TRAP_EN
    localparam logic [W-1:0] DZ_POS = 32'h7F800000;
    localparam logic [W-1:0] DZ_NEG = 32'hFF800000;
    localparam logic         DZ_ERR = 1'b1;
`else
    localparam logic [W-1:0] DZ_POS = 32'h00000000;
    localparam logic [W-1:0] DZ_NEG = 32'h00000000;
    localparam logic         DZ_ERR = 1'b0;
`endif

    typedef struct {
        logic         id;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic id, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_timeout", W'(n < 50), 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    // Latency = posedges after the accepting edge until rsp_valid is seen high.
    task automatic finish_op(input string tag, input logic exp_id, input logic [1:0] op,
                             input logic [W-1:0] exp_res, input logic exp_err, input int en_before);
        int lat;
        lat = 0;
        #1;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        chk({tag, " latency"}, W'(lat), (op == 2'd3) ? 0 : LAT + 1);
        chk({tag, " rsp_id"}, W'(rsp_id), W'(exp_id));
        chk({tag, " rsp_result"}, rsp_result, exp_res);
        chk({tag, " rsp_err"}, W'(rsp_err), W'(exp_err));
        chk({tag, " dp_en_cycles"}, W'(en_cycles - en_before), (op == 2'd3) ? 0 : LAT + 1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid_after_ack"}, W'(rsp_valid), 0);
    endtask

    vec_t vecs[8];

    initial begin
        int  n;
        int  en_b;
        int  lat;
        logic g;
        logic stable;

        vecs[0] = '{1'b0, 2'd2, 32'h40400000, 32'h40000000, 32'h3FC00000, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0};
        vecs[2] = '{1'b1, 2'd3, 32'h12345678, 32'h9ABCDEF0, 32'h7FC00000, 1'b1};
        vecs[3] = '{1'b0, 2'd1, 32'h40000000, 32'h40400000, 32'h40C00000, 1'b0};
        vecs[4] = '{1'b0, 2'd2, 32'h40400000, 32'h00000000, DZ_POS, DZ_ERR};
        vecs[5] = '{1'b0, 2'd3, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b1};
        vecs[6] = '{1'b1, 2'd2, 32'hC0800000, 32'h40000000, 32'hC0000000, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 32'hC0800000, 32'h00000000, DZ_NEG, DZ_ERR};

        repeat (2) @(negedge clk);
        #1;
        chk("reset ready", W'({req0_ready, req1_ready}), 0);
        chk("reset dp_en", W'(dp_en), 0);
        chk("reset dp_op", W'(dp_op), 0);
        chk("reset dp_a", dp_a, 0);
        chk("reset dp_b", dp_b, 0);
        chk("reset rsp", W'({rsp_valid, rsp_id, rsp_err}), 0);
        chk("reset rsp_result", rsp_result, 0);
        rst = 1'b0;

        // Both requesters valid for four consecutive ops: grants must alternate starting with 0.
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'h3F800000; req0_b = 32'h40000000;
        req1_valid = 1'b1; req1_op = 2'd1; req1_a = 32'h40000000; req1_b = 32'h40400000;
        for (int k = 0; k < 4; k++) begin
            en_b = en_cycles;
            #1;
            n = 0;
            while (!(req0_ready || req1_ready) && n < 50) begin
                @(negedge clk); #1; n++;
            end
            chk($sformatf("rr%0d accept_timeout", k), W'(n < 50), 1);
            chk($sformatf("rr%0d both_ready", k), W'(req0_ready && req1_ready), 0);
            g = req1_ready;
            chk($sformatf("rr%0d grant", k), W'(g), W'(k % 2));
            @(negedge clk);
            finish_op($sformatf("rr%0d", k), k[0], g ? 2'd1 : 2'd0,
                      g ? 32'h40C00000 : 32'h40400000, 1'b0, en_b);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            en_b = en_cycles;
            start_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            finish_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].res, vecs[i].err, en_b);
`ifdef FPU_SCHED_DZ_TRAP_EN
            chk($sformatf("vec%0d dz_sticky", i), W'(dz_sticky), W'(i >= 4));
`endif
        end

        // Response back-pressure with a pending request that must survive the stall.
        start_op(1'b0, 2'd1, 32'h40000000, 32'h40400000);
        n = 0;
        #1;
        while (!rsp_valid && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("stall rsp_timeout", W'(n < 50), 1);
        req0_valid = 1'b1; req0_op = 2'd0; req0_a = 32'h3F800000; req0_b = 32'h3F800000;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (!(rsp_valid && rsp_result == 32'h40C00000 && !rsp_id && !rsp_err && !req0_ready
                  && dp_op == 2'd1 && dp_a == 32'h40000000 && dp_b == 32'h40400000 && !dp_en))
                stable = 1'b0;
        end
        chk("stall rsp_stable", W'(stable), 1);
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        rsp_ready = 1'b0;
        chk("stall rsp_valid_after_ack", W'(rsp_valid), 0);
        chk("stall pending_ready", W'(req0_ready), 1);
        en_b = en_cycles;
        @(negedge clk);
        req0_valid = 1'b0;
        finish_op("stall_pending", 1'b0, 2'd0, 32'h40000000, 1'b0, en_b);

        // Asynchronous reset while the op sits in WAIT.
        start_op(1'b0, 2'd2, 32'h40400000, 32'h40000000);
        @(negedge clk); #1;
        chk("rst_mid dp_en_before", W'(dp_en), 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid dp_en", W'(dp_en), 0);
        chk("rst_mid rsp_valid", W'(rsp_valid), 0);
        chk("rst_mid dp_a", dp_a, 0);
        chk("rst_mid dp_op", W'(dp_op), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mid no_stale_rsp", W'(rsp_valid), 0);
        en_b = en_cycles;
        start_op(1'b0, 2'd2, 32'h40800000, 32'h40000000);
        finish_op("after_rst", 1'b0, 2'd2, 32'h40000000, 1'b0, en_b);

        // Three-cycle datapath instance.
        en_b = en3_cycles;
        @(negedge clk);
        r3_valid = 1'b1; r3_op = 2'd2; r3_a = 32'h40800000; r3_b = 32'h40000000;
        #1;
        n = 0;
        while (!r3_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("lat3 accept_timeout", W'(n < 50), 1);
        @(negedge clk);
        r3_valid = 1'b0;
        lat = 0;
        #1;
        while (!r3_rsp_valid && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        chk("lat3 latency", W'(lat), 4);
        chk("lat3 rsp_result", r3_rsp_result, 32'h40000000);
        chk("lat3 rsp_id_err", W'({r3_rsp_id, r3_rsp_err}), 0);
        chk("lat3 dp_en_cycles", W'(en3_cycles - en_b), 4);
        r3_rsp_ready = 1'b1;
        @(negedge clk); #1;
        r3_rsp_ready = 1'b0;
        chk("lat3 rsp_valid_after_ack", W'(r3_rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
